sht21_meas_sequencer: RTL and testbench

//  Master-side scheduler for one SHT21 temperature + humidity acquisition. Sequences a byte-level
//  I2C master engine through the SHT21 no-hold protocol: trigger, wait, poll, read 3 bytes, CRC check.

---
 rtl/sht21_meas_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sht21_meas_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sht21_meas_sequencer.sv
// SHT21 no-hold acquisition sequencer: drives a byte-level I2C engine through
// trigger, wait, poll, read and CRC check for a temperature then a humidity phase.
module sht21_meas_sequencer #(
  parameter logic [6:0]  DEV_ADDR    = 7'h40,
  parameter int unsigned WAIT_CYCLES = 340000,
  parameter int unsigned POLL_CYCLES = 4000,
  parameter int unsigned MAX_POLLS   = 30,
  parameter int unsigned CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] temp_raw,
  output logic [15:0] rh_raw,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack
);

  localparam int unsigned PW = $clog2(MAX_POLLS + 1);

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_READ_ACK  = 3'd2;
  localparam logic [2:0] OP_READ_NACK = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_CHECK   = 2'd3;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [PW-1:0]    POLL_MAX  = PW'(MAX_POLLS);

  typedef enum logic [3:0] {
    S_IDLE, S_TRIG, S_WAIT, S_POLL, S_PWAIT, S_READ, S_CHECK, S_ABORT, S_FIN
  } state_e;

  state_e           state_q;
  logic [1:0]       step_q;
  logic             ph_q;
  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    polls_q;
  logic [7:0]       msb_q;
  logic [7:0]       lsb_q;
  logic [7:0]       crcByte_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic [15:0]      temp_q;
  logic [15:0]      rh_q;
  logic             cmdValid_q;
  logic [2:0]       cmdOp_q;
  logic [7:0]       cmdWdata_q;

  logic             needCmd;
  logic [2:0]       issueOp;
  logic [7:0]       issueData;
  logic             rspTake;
  logic [7:0]       crcCalc;
  logic             checkOk;
  logic [PW-1:0]    polls_d;

  function automatic logic [7:0] crc8Step(input logic [7:0] crcIn, input logic [7:0] data);
    logic [7:0] c;
    c = crcIn ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  // Which bus command the current state/step wants on the engine interface.
  always_comb begin
    needCmd   = 1'b0;
    issueOp   = OP_STOP;
    issueData = 8'h00;
    case (state_q)
      S_TRIG: begin
        needCmd = 1'b1;
        case (step_q)
          2'd0: issueOp = OP_START;
          2'd1: begin issueOp = OP_WRITE; issueData = {DEV_ADDR, 1'b0}; end
          2'd2: begin issueOp = OP_WRITE; issueData = ph_q ? 8'hF5 : 8'hF3; end
          default: issueOp = OP_STOP;
        endcase
      end
      S_POLL: begin
        needCmd = 1'b1;
        case (step_q)
          2'd0: issueOp = OP_START;
          2'd1: begin issueOp = OP_WRITE; issueData = {DEV_ADDR, 1'b1}; end
          default: issueOp = OP_STOP;
        endcase
      end
      S_READ: begin
        needCmd = 1'b1;
        case (step_q)
          2'd0, 2'd1: issueOp = OP_READ_ACK;
          2'd2:       issueOp = OP_READ_NACK;
          default:    issueOp = OP_STOP;
        endcase
      end
      S_ABORT: needCmd = (code_q == ERR_NACK);
      default: ;
    endcase
  end

  assign rspTake = inflight_q && rsp_valid;
  assign crcCalc = crc8Step(crc8Step(8'h00, msb_q), lsb_q);
  assign checkOk = (crcCalc == crcByte_q) && (lsb_q[1] == ph_q);
  assign polls_d = polls_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 2'd0;
      ph_q       <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      polls_q    <= '0;
      msb_q      <= 8'h00;
      lsb_q      <= 8'h00;
      crcByte_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      temp_q     <= 16'h0000;
      rh_q       <= 16'h0000;
      cmdValid_q <= 1'b0;
      cmdOp_q    <= OP_START;
      cmdWdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;

      // One command in flight: hold it until accepted, then wait for its response.
      if (cmdValid_q && cmd_ready) begin
        cmdValid_q <= 1'b0;
        inflight_q <= 1'b1;
      end else if (needCmd && !cmdValid_q && !inflight_q) begin
        cmdValid_q <= 1'b1;
        cmdOp_q    <= issueOp;
        cmdWdata_q <= issueData;
      end
      if (rspTake) inflight_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            ph_q    <= 1'b0;
            step_q  <= 2'd0;
            state_q <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (rspTake) begin
            if ((step_q == 2'd1 || step_q == 2'd2) && rsp_nack) begin
              code_q  <= ERR_NACK;
              state_q <= S_ABORT;
            end else if (step_q == 2'd3) begin
              cnt_q   <= '0;
              polls_q <= '0;
              state_q <= S_WAIT;
            end else begin
              step_q <= step_q + 2'd1;
            end
          end
        end
        // The poll START is preloaded on the last count so the dwell is exactly N idle cycles.
        S_WAIT, S_PWAIT: begin
          if (cnt_q == ((state_q == S_WAIT) ? WAIT_LAST : POLL_LAST)) begin
            cnt_q      <= '0;
            step_q     <= 2'd0;
            state_q    <= S_POLL;
            cmdValid_q <= 1'b1;
            cmdOp_q    <= OP_START;
            cmdWdata_q <= 8'h00;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_POLL: begin
          if (rspTake) begin
            case (step_q)
              2'd0: step_q <= 2'd1;
              2'd1: begin
                if (rsp_nack) begin
                  step_q <= 2'd2;
                end else begin
                  step_q  <= 2'd0;
                  state_q <= S_READ;
                end
              end
              default: begin
                if (polls_q != POLL_MAX) polls_q <= polls_d;
                if (polls_d == POLL_MAX) begin
                  code_q  <= ERR_TIMEOUT;
                  state_q <= S_ABORT;
                end else begin
                  cnt_q   <= '0;
                  state_q <= S_PWAIT;
                end
              end
            endcase
          end
        end
        S_READ: begin
          if (rspTake) begin
            case (step_q)
              2'd0:    msb_q     <= rsp_data;
              2'd1:    lsb_q     <= rsp_data;
              2'd2:    crcByte_q <= rsp_data;
              default: state_q   <= S_CHECK;
            endcase
            step_q <= step_q + 2'd1;
          end
        end
        S_CHECK: begin
          if (!checkOk) begin
            code_q  <= ERR_CHECK;
            state_q <= S_FIN;
          end else if (!ph_q) begin
            temp_q  <= {msb_q, lsb_q[7:2], 2'b00};
            ph_q    <= 1'b1;
            step_q  <= 2'd0;
            state_q <= S_TRIG;
          end else begin
            rh_q    <= {msb_q, lsb_q[7:2], 2'b00};
            state_q <= S_FIN;
          end
        end
        S_ABORT: begin
          if (code_q != ERR_NACK || rspTake) state_q <= S_FIN;
        end
        S_FIN: begin
          done_q  <= 1'b1;
          err_q   <= (code_q != ERR_NONE);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign temp_raw  = temp_q;
  assign rh_raw    = rh_q;
  assign cmd_valid = cmdValid_q;
  assign cmd_op    = cmdOp_q;
  assign cmd_wdata = cmdWdata_q;

endmodule

// File: tb/tb_sht21_meas_sequencer.sv
// Directed bench for sht21_meas_sequencer with a scripted I2C engine model that
// logs every accepted command and answers after a programmable latency.
module tb_sht21_meas_sequencer;

  localparam int WAITC = 20;
  localparam int POLLC = 10;
  localparam int MAXP  = 30;

  localparam logic [2:0] OP_START = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_RA    = 3'd2;
  localparam logic [2:0] OP_RN    = 3'd3;
  localparam logic [2:0] OP_STOP  = 3'd4;

  logic        clk = 1'b0;
  logic        rst, start, cmd_ready, rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;
  logic        busy, done, err, cmd_valid;
  logic [1:0]  err_code;
  logic [15:0] temp_raw, rh_raw;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_wdata;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  sht21_meas_sequencer #(
    .DEV_ADDR(7'h40), .WAIT_CYCLES(WAITC), .POLL_CYCLES(POLLC), .MAX_POLLS(MAXP), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .temp_raw(temp_raw), .rh_raw(rh_raw),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: records accepted commands at the negedge before the accepting edge
  // and pulses rsp_valid rspLat negedges later.
  logic [2:0] opQ[$];
  logic [7:0] dataQ[$];
  int         cycQ[$];
  int         rspCycQ[$];
  logic [7:0] readQ[$];
  int         rspLat = 2;
  int         rspDelay = 0;
  logic [7:0] pendData = 8'h00;
  logic       pendNack = 1'b0;
  bit         trigNack = 1'b0;
  bit         pollNackAll = 1'b0;
  int         pollNackLeft = 0;

  initial begin
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;
    rsp_nack  = 1'b0;
  end

  always @(negedge clk) begin
    rsp_valid = 1'b0;
    if (rspDelay > 0) begin
      rspDelay--;
      if (rspDelay == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = pendData;
        rsp_nack  = pendNack;
        rspCycQ.push_back(cyc);
      end
    end else if (cmd_valid && cmd_ready && !rst) begin
      opQ.push_back(cmd_op);
      dataQ.push_back(cmd_wdata);
      cycQ.push_back(cyc);
      pendData = 8'h00;
      pendNack = 1'b0;
      if (cmd_op == OP_WRITE) begin
        if (cmd_wdata == 8'h80) pendNack = trigNack;
        else if (cmd_wdata == 8'h81) begin
          if (pollNackAll) pendNack = 1'b1;
          else if (pollNackLeft > 0) begin
            pendNack = 1'b1;
            pollNackLeft--;
          end
        end
      end else if (cmd_op == OP_RA || cmd_op == OP_RN) begin
        pendData = (readQ.size() > 0) ? readQ.pop_front() : 8'hFF;
      end
      rspDelay = rspLat;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    checkOutput({tag, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic waitLog(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (opQ.size() >= n) break;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_logwait"}, {31'b0, opQ.size() >= n}, 32'd1);
  endtask

  task automatic clearLog();
    opQ.delete(); dataQ.delete(); cycQ.delete(); rspCycQ.delete(); readQ.delete();
  endtask

  task automatic pushBytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    readQ.push_back(a); readQ.push_back(b); readQ.push_back(c);
  endtask

  logic [10:0] expT1 [20];
  int          cntW81, cntF5;
  bit          sawActivity;

  initial begin
    rst = 1'b1; start = 1'b0; cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy_in_reset", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_outputs", {busy, done, err, err_code, cmd_valid, cmd_op, cmd_wdata},
                {1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 8'h00});
    checkOutput("rst_raw", {temp_raw, rh_raw}, 32'h0);

    $display("[TB] test 1: full temp + RH acquisition");
    clearLog();
    pushBytes(8'h68, 8'h38, 8'h1E);
    pushBytes(8'h4E, 8'h86, 8'h38);
    applyStimulus();
    checkOutput("t1_busy_after_start", {31'b0, busy}, 32'd1);
    waitDone("t1", 3000);
    checkOutput("t1_err", {29'b0, err, err_code}, 32'd0);
    checkOutput("t1_temp", {16'b0, temp_raw}, 32'h6838);
    checkOutput("t1_rh", {16'b0, rh_raw}, 32'h4E84);
    expT1 = '{ {OP_START, 8'h00}, {OP_WRITE, 8'h80}, {OP_WRITE, 8'hF3}, {OP_STOP, 8'h00},
               {OP_START, 8'h00}, {OP_WRITE, 8'h81}, {OP_RA, 8'h00}, {OP_RA, 8'h00},
               {OP_RN, 8'h00}, {OP_STOP, 8'h00},
               {OP_START, 8'h00}, {OP_WRITE, 8'h80}, {OP_WRITE, 8'hF5}, {OP_STOP, 8'h00},
               {OP_START, 8'h00}, {OP_WRITE, 8'h81}, {OP_RA, 8'h00}, {OP_RA, 8'h00},
               {OP_RN, 8'h00}, {OP_STOP, 8'h00} };
    checkOutput("t1_len", opQ.size(), 32'd20);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("t1_trace%0d", i),
                  (i < opQ.size()) ? {21'b0, opQ[i], dataQ[i]} : 32'hFFFF_FFFF, {21'b0, expT1[i]});
    end
    // STOP response cycle, then WAITC idle cycles, then START is logged.
    checkOutput("t1_wait_gap", cycQ[4] - rspCycQ[3], WAITC + 1);
    @(posedge clk); #1;
    checkOutput("t1_done_one_cycle", {31'b0, done}, 32'd0);

    $display("[TB] test 2: trigger address NACK");
    clearLog();
    trigNack = 1'b1;
    applyStimulus();
    waitDone("t2", 500);
    checkOutput("t2_err", {29'b0, err, err_code}, {29'b0, 1'b1, 2'd1});
    checkOutput("t2_raw_kept", {temp_raw, rh_raw}, 32'h6838_4E84);
    checkOutput("t2_len", opQ.size(), 32'd3);
    checkOutput("t2_stop", {29'b0, opQ[2]}, {29'b0, OP_STOP});
    trigNack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 3: three NACKed polls then ACK");
    clearLog();
    pollNackLeft = 3;
    pushBytes(8'h68, 8'h38, 8'h1E);
    pushBytes(8'h4E, 8'h86, 8'h38);
    applyStimulus();
    checkOutput("t3_err_cleared", {31'b0, err}, 32'd0);
    waitDone("t3", 3000);
    checkOutput("t3_err", {29'b0, err, err_code}, 32'd0);
    checkOutput("t3_len", opQ.size(), 32'd29);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("t3_stop%0d", k), {29'b0, opQ[6 + 3 * k]}, {29'b0, OP_STOP});
      checkOutput($sformatf("t3_gap%0d", k), cycQ[7 + 3 * k] - rspCycQ[6 + 3 * k], POLLC + 1);
    end
    checkOutput("t3_raw", {temp_raw, rh_raw}, 32'h6838_4E84);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 4: poll timeout");
    clearLog();
    pollNackAll = 1'b1;
    applyStimulus();
    waitDone("t4", 5000);
    checkOutput("t4_err", {29'b0, err, err_code}, {29'b0, 1'b1, 2'd2});
    checkOutput("t4_len", opQ.size(), 32'd94);
    cntW81 = 0; cntF5 = 0;
    for (int i = 0; i < opQ.size(); i++) begin
      if (opQ[i] == OP_WRITE && dataQ[i] == 8'h81) cntW81++;
      if (opQ[i] == OP_WRITE && dataQ[i] == 8'hF5) cntF5++;
    end
    checkOutput("t4_polls", cntW81, MAXP);
    checkOutput("t4_no_rh", cntF5, 32'd0);
    checkOutput("t4_last_stop", {29'b0, opQ[opQ.size() - 1]}, {29'b0, OP_STOP});
    pollNackAll = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 5: bad temperature CRC");
    clearLog();
    pushBytes(8'h70, 8'h10, 8'h79);
    applyStimulus();
    waitDone("t5", 3000);
    checkOutput("t5_err", {29'b0, err, err_code}, {29'b0, 1'b1, 2'd3});
    checkOutput("t5_raw_kept", {temp_raw, rh_raw}, 32'h6838_4E84);
    checkOutput("t5_len", opQ.size(), 32'd10);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 5b: valid CRC but status bit says humidity in temp phase");
    clearLog();
    pushBytes(8'h68, 8'h3A, 8'h7C);
    applyStimulus();
    waitDone("t5b", 3000);
    checkOutput("t5b_err", {29'b0, err, err_code}, {29'b0, 1'b1, 2'd3});
    checkOutput("t5b_len", opQ.size(), 32'd10);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 6: backpressure, busy start, reset mid-read");
    clearLog();
    pushBytes(8'h68, 8'h38, 8'h1E);
    applyStimulus();
    checkOutput("t6_err_cleared", {29'b0, err, err_code}, 32'd0);
    waitLog("t6_start", 1, 20);
    cmd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 50; i++) begin
      checkOutput($sformatf("t6_hold%0d", i), {20'b0, cmd_valid, cmd_op, cmd_wdata},
                  {20'b0, 1'b1, OP_WRITE, 8'h80});
      @(posedge clk); #1;
    end
    cmd_ready = 1'b1;
    waitLog("t6_trigstop", 4, 100);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("t6_busy_start_busy", {31'b0, busy}, 32'd1);
    waitLog("t6_poll", 6, 200);
    checkOutput("t6_busy_start_ignored", {21'b0, opQ[5], dataQ[5]}, {21'b0, OP_WRITE, 8'h81});
    rspLat = 5;
    waitLog("t6_read", 7, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_rst_idle", {29'b0, busy, done, cmd_valid}, 32'd0);
    checkOutput("t6_rst_raw", {temp_raw, rh_raw}, 32'h0);
    rst = 1'b0;
    sawActivity = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || done || cmd_valid) sawActivity = 1'b1;
    end
    checkOutput("t6_late_rsp_ignored", {31'b0, sawActivity}, 32'd0);

    $display("[TB] test 6b: recovery after reset");
    rspLat = 2;
    clearLog();
    pushBytes(8'h68, 8'h38, 8'h1E);
    pushBytes(8'h4E, 8'h86, 8'h38);
    applyStimulus();
    waitDone("t6b", 3000);
    checkOutput("t6b_err", {29'b0, err, err_code}, 32'd0);
    checkOutput("t6b_raw", {temp_raw, rh_raw}, 32'h6838_4E84);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
